multi_cycle_ctrl: RTL
=====================

MULTI_CYCLE_CTRL -- requirements
Module: multi_cycle_ctrl

Interface
REQ-001 SHALL use one clock and synchronous active-high reset: CLK input 1 rising-edge clock; Reset input 1 synchronous, active-high.
REQ-002 SHALL have port op, input, 6 bits: opcode field of the instruction register (IR); valid from the cycle after IF.
REQ-003 SHALL have port zero, input, 1 bit: ALU zero flag.
REQ-004 SHALL have port PCWre, output, 1 bit: PC write enable.
REQ-005 SHALL have port IRWre, output, 1 bit: IR load enable.
REQ-006 SHALL have port InsMemRW, output, 1 bit: instruction memory read enable.
REQ-007 SHALL have these mux selects and enables, all outputs, 1 bit each: ALUSrcB, ALUM2Reg, RegWre, DataMemRW, ExtSel, RegOut, PCSrc.
REQ-008 SHALL have port ALUOp, output, 3 bits: ALU function; 000 add, 001 sub, 011 or, 100 and.
REQ-009 SHALL have port state, output, 4 bits: current FSM state, for debug.
REQ-010 SHALL have port illegal, output, 1 bit: pulses for one cycle in ID when op is undefined.

Function
REQ-011 SHALL implement a Moore FSM with states IF=0000, ID=0001, EXE_AL=0010, WB_AL=0011, EXE_LS=0100, MEM=0101, WB_LD=0110, EXE_BR=0111, HALT=1000; outputs are decoded from state and op only. The only exception is PCSrc, which also depends on zero.
REQ-012 SHALL follow the transition IF->ID unconditionally.
REQ-013 SHALL leave ID as follows:
- op in {add 000000, addi 000001, sub 000010, ori 010000, and 010001, or 010010, move 100000} -> EXE_AL
- op in {sw 100110, lw 100111} -> EXE_LS
- beq 110000 -> EXE_BR
- halt 111111 -> HALT
- any other op -> IF, with illegal=1 and no writes.
REQ-014 SHALL use these transitions: EXE_AL->WB_AL->IF; EXE_LS->MEM; MEM->WB_LD for lw; MEM->IF for sw; WB_LD->IF; EXE_BR->IF; HALT->HALT until Reset.
REQ-015 SHALL take these cycles per instruction: ALU ops 4, sw 4, lw 5, beq 3; halt stops after 2.
REQ-016 SHALL drive, in IF: InsMemRW=1, IRWre=1; all other enables 0.
REQ-017 SHALL drive PCWre=1 only in the final state of each instruction (WB_AL, MEM for sw, WB_LD, EXE_BR); PCWre=0 in all other states, including ID on an illegal op. The PC therefore advances exactly once per instruction.
REQ-018 SHALL drive RegWre=1 only in WB_AL and WB_LD, and DataMemRW=1 only in MEM with op=sw.
REQ-019 SHALL drive, in EXE_AL/WB_AL:
- ALUSrcB=1 for addi/ori, else 0
- RegOut=0 for addi/ori, else 1
- ExtSel=1 for addi, 0 for ori and others
- ALUOp: add/addi/move 000, sub 001, or/ori 011, and 100.
REQ-020 SHALL drive, in EXE_LS/MEM/WB_LD: ALUSrcB=1, ExtSel=1, ALUOp=000, RegOut=0; ALUM2Reg=1 in WB_LD only.
REQ-021 SHALL drive, in EXE_BR: ALUOp=001, ALUSrcB=0, ExtSel=1, PCSrc=zero. PCSrc=0 in every other state.
REQ-022 SHALL hold, in HALT: all enables 0, ALUOp=000; op and zero are ignored.
REQ-023 SHALL hold op-dependent outputs stable from ID until the instruction completes, relying on IR, which changes only when IRWre=1.

Reset
REQ-024 SHALL, in any cycle where Reset=1 at the CLK edge, load state=IF, regardless of current state (including mid-instruction and HALT).
REQ-025 SHALL force PCWre, RegWre, DataMemRW and IRWre to 0 while Reset is high, so no architectural write occurs during reset; IF outputs resume on the first cycle after release.
REQ-026 SHALL reset all other outputs to 0 and illegal to 0.

Structure
REQ-027 SHALL place opcode constants, state encodings and ALUOp codes in shared package cpu_pkg, which the ALU and datapath also use.
REQ-028 SHALL split into the state register plus next-state logic in multi_cycle_ctrl, and one combinational sub-module ctrl_decode (inputs state, op, zero; outputs all control signals).

Verification
REQ-029 SHALL cover: Reset 2 cycles, then op=000000 (add) -> states IF,ID,EXE_AL,WB_AL,IF; RegWre=1 only in cycle 4; PCWre=1 only in cycle 4; ALUOp=000, RegOut=1.
REQ-030 SHALL cover: op=100111 (lw) -> 5 cycles; ALUM2Reg=1 and RegWre=1 in WB_LD only; DataMemRW never 1. Then op=100110 (sw) -> 4 cycles; DataMemRW=1 only in MEM, alongside PCWre=1.
REQ-031 SHALL cover beq in EXE_BR: op=110000 with zero=1 -> PCSrc=1, PCWre=1; with zero=0 -> PCSrc=0, PCWre=1; 3 cycles each; RegWre stays 0.
REQ-032 SHALL cover: op=111111 -> HALT after ID, held for 20 cycles with all enables 0 while op and zero toggle; Reset=1 -> state=IF next cycle.
REQ-033 SHALL cover: op=001111 (undefined) -> illegal=1 for one cycle in ID, then IF; no PCWre, RegWre or DataMemRW pulses.
REQ-034 SHALL cover: Reset asserted in WB_AL and in MEM -> state=IF after the edge; RegWre and DataMemRW = 0 in that cycle.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU constants: opcodes, FSM state encodings, ALU codes.
// Used by the control unit, the ALU and the datapath.
package cpu_pkg;

  typedef enum logic [3:0] {
    S_IF     = 4'b0000,
    S_ID     = 4'b0001,
    S_EXE_AL = 4'b0010,
    S_WB_AL  = 4'b0011,
    S_EXE_LS = 4'b0100,
    S_MEM    = 4'b0101,
    S_WB_LD  = 4'b0110,
    S_EXE_BR = 4'b0111,
    S_HALT   = 4'b1000
  } state_e;

  localparam logic [5:0] OP_ADD  = 6'b000000;
  localparam logic [5:0] OP_ADDI = 6'b000001;
  localparam logic [5:0] OP_SUB  = 6'b000010;
  localparam logic [5:0] OP_ORI  = 6'b010000;
  localparam logic [5:0] OP_AND  = 6'b010001;
  localparam logic [5:0] OP_OR   = 6'b010010;
  localparam logic [5:0] OP_MOVE = 6'b100000;
  localparam logic [5:0] OP_SW   = 6'b100110;
  localparam logic [5:0] OP_LW   = 6'b100111;
  localparam logic [5:0] OP_BEQ  = 6'b110000;
  localparam logic [5:0] OP_HALT = 6'b111111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_AND = 3'b100;

  typedef enum logic [2:0] {
    CL_AL,
    CL_LS,
    CL_BR,
    CL_HALT,
    CL_ILL
  } op_class_e;

  function automatic op_class_e op_class(
    input logic [5:0] op
  );
    case (op)
      OP_ADD, OP_ADDI, OP_SUB, OP_ORI,
      OP_AND, OP_OR, OP_MOVE: return CL_AL;
      OP_SW, OP_LW:           return CL_LS;
      OP_BEQ:                 return CL_BR;
      OP_HALT:                return CL_HALT;
      default:                return CL_ILL;
    endcase
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational control decode from FSM state, opcode and zero flag.
// Ports: state/op/zero in; all datapath enables, selects, ALUOp, illegal out.
module ctrl_decode
  import cpu_pkg::*;
(
  input  state_e     state,
  input  logic [5:0] op,
  input  logic       zero,
  output logic       PCWre,
  output logic       IRWre,
  output logic       InsMemRW,
  output logic       ALUSrcB,
  output logic       ALUM2Reg,
  output logic       RegWre,
  output logic       DataMemRW,
  output logic       ExtSel,
  output logic       RegOut,
  output logic       PCSrc,
  output logic [2:0] ALUOp,
  output logic       illegal
);

  op_class_e  cls;
  logic       al_imm;
  logic [2:0] al_op;

  assign cls    = op_class(op);
  assign al_imm = (op == OP_ADDI) || (op == OP_ORI);

  always_comb begin
    al_op = ALU_ADD;
    case (op)
      OP_SUB:        al_op = ALU_SUB;
      OP_OR, OP_ORI: al_op = ALU_OR;
      OP_AND:        al_op = ALU_AND;
      default:       al_op = ALU_ADD;
    endcase
  end

  always_comb begin
    PCWre     = 1'b0;
    IRWre     = 1'b0;
    InsMemRW  = 1'b0;
    ALUSrcB   = 1'b0;
    ALUM2Reg  = 1'b0;
    RegWre    = 1'b0;
    DataMemRW = 1'b0;
    ExtSel    = 1'b0;
    RegOut    = 1'b0;
    PCSrc     = 1'b0;
    ALUOp     = ALU_ADD;
    illegal   = 1'b0;
    case (state)
      S_IF: begin
        InsMemRW = 1'b1;
        IRWre    = 1'b1;
      end
      // Selects settle in ID so they are stable through EXE.
      S_ID: begin
        unique case (cls)
          CL_AL: begin
            ALUSrcB = al_imm;
            RegOut  = ~al_imm;
            ExtSel  = (op == OP_ADDI);
            ALUOp   = al_op;
          end
          CL_LS: begin
            ALUSrcB = 1'b1;
            ExtSel  = 1'b1;
          end
          CL_BR: begin
            ALUOp  = ALU_SUB;
            ExtSel = 1'b1;
          end
          CL_HALT: ;
          CL_ILL: illegal = 1'b1;
        endcase
      end
      S_EXE_AL, S_WB_AL: begin
        ALUSrcB = al_imm;
        RegOut  = ~al_imm;
        ExtSel  = (op == OP_ADDI);
        ALUOp   = al_op;
        RegWre  = (state == S_WB_AL);
        PCWre   = (state == S_WB_AL);
      end
      S_EXE_LS, S_MEM, S_WB_LD: begin
        ALUSrcB   = 1'b1;
        ExtSel    = 1'b1;
        ALUM2Reg  = (state == S_WB_LD);
        RegWre    = (state == S_WB_LD);
        DataMemRW = (state == S_MEM) && (op == OP_SW);
        PCWre     = (state == S_WB_LD) ||
                    ((state == S_MEM) && (op == OP_SW));
      end
      S_EXE_BR: begin
        ALUOp  = ALU_SUB;
        ExtSel = 1'b1;
        PCSrc  = zero;
        PCWre  = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle CPU control FSM: state register, next-state, output gating.
// Ports: CLK, Reset, op, zero in; control enables, ALUOp, state, illegal out.
module multi_cycle_ctrl
  import cpu_pkg::*;
(
  input  logic       CLK,
  input  logic       Reset,
  input  logic [5:0] op,
  input  logic       zero,
  output logic       PCWre,
  output logic       IRWre,
  output logic       InsMemRW,
  output logic       ALUSrcB,
  output logic       ALUM2Reg,
  output logic       RegWre,
  output logic       DataMemRW,
  output logic       ExtSel,
  output logic       RegOut,
  output logic       PCSrc,
  output logic [2:0] ALUOp,
  output logic [3:0] state,
  output logic       illegal
);

  state_e     st;
  logic       d_pcw, d_irw, d_imr, d_asb, d_am;
  logic       d_rw, d_dm, d_ext, d_ro, d_psrc, d_ill;
  logic [2:0] d_aluop;

  always_ff @(posedge CLK) begin
    if (Reset) begin
      st <= S_IF;
    end else begin
      case (st)
        S_IF: st <= S_ID;
        S_ID: begin
          unique case (op_class(op))
            CL_AL:   st <= S_EXE_AL;
            CL_LS:   st <= S_EXE_LS;
            CL_BR:   st <= S_EXE_BR;
            CL_HALT: st <= S_HALT;
            CL_ILL:  st <= S_IF;
          endcase
        end
        S_EXE_AL: st <= S_WB_AL;
        S_WB_AL:  st <= S_IF;
        S_EXE_LS: st <= S_MEM;
        S_MEM:    st <= (op == OP_LW) ? S_WB_LD : S_IF;
        S_WB_LD:  st <= S_IF;
        S_EXE_BR: st <= S_IF;
        S_HALT:   st <= S_HALT;
        default:  st <= S_IF;
      endcase
    end
  end

  ctrl_decode u_dec (
    .state     (st),
    .op        (op),
    .zero      (zero),
    .PCWre     (d_pcw),
    .IRWre     (d_irw),
    .InsMemRW  (d_imr),
    .ALUSrcB   (d_asb),
    .ALUM2Reg  (d_am),
    .RegWre    (d_rw),
    .DataMemRW (d_dm),
    .ExtSel    (d_ext),
    .RegOut    (d_ro),
    .PCSrc     (d_psrc),
    .ALUOp     (d_aluop),
    .illegal   (d_ill)
  );

  // Reset masks every output so nothing is written mid-reset.
  assign PCWre     = d_pcw  & ~Reset;
  assign IRWre     = d_irw  & ~Reset;
  assign InsMemRW  = d_imr  & ~Reset;
  assign ALUSrcB   = d_asb  & ~Reset;
  assign ALUM2Reg  = d_am   & ~Reset;
  assign RegWre    = d_rw   & ~Reset;
  assign DataMemRW = d_dm   & ~Reset;
  assign ExtSel    = d_ext  & ~Reset;
  assign RegOut    = d_ro   & ~Reset;
  assign PCSrc     = d_psrc & ~Reset;
  assign illegal   = d_ill  & ~Reset;
  assign ALUOp     = Reset ? ALU_ADD : d_aluop;
  assign state     = st;

endmodule
